mult_div_unit: RTL and testbench
================================

// Module: mult_div_unit
// PURPOSE
//  Multi-cycle MIPS multiply/divide engine; producer side of the HI/LO register pair.
//  Runs MULT, MULTU, DIV and DIVU iteratively (one bit per cycle).
//  Presents 32-bit HI/LO results with a one-cycle load strobe that drives Ld of the HI and LO registers.
//  Busy lets the pipeline stall MFHI/MFLO until the result is written.
// PARAMETERS
//  WIDTH  32  operand width; the HI and LO results are each WIDTH bits; iteration count = WIDTH
// PORTS
//  Clk      in   1      clock, rising edge
//  Clr      in   1      reset, asynchronous, active-high
//  Start    in   1      request operation; sampled only in IDLE
//  Op       in   2      00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with Start
//  A        in   WIDTH  multiplicand / dividend (rs); sampled with Start
//  B        in   WIDTH  multiplier / divisor (rt); sampled with Start
//  Busy     out  1      high in RUN and FIX
//  HiLo_Ld  out  1      one-cycle load strobe to the HI/LO registers (DONE state)
//  Hi_out   out  WIDTH  product[63:32] / remainder
//  Lo_out   out  WIDTH  product[31:0] / quotient
// BEHAVIOUR
//  - Clr=1 (any time, async): state=IDLE; Busy=0, HiLo_Ld=0, Hi_out=0, Lo_out=0; counter and datapath regs=0.
//    Clr during RUN/FIX aborts the operation; no HiLo_Ld is issued.
//  - FSM IDLE -> RUN -> FIX -> DONE -> IDLE.
//    IDLE: Start=1 at edge E0 latches Op, |A|, |B| and the sign flags; counter=0; go to RUN.
//      Magnitude conversion applies to signed ops only; unsigned ops take A and B as-is.
//    RUN: one iteration per edge for WIDTH edges (E1..E32); go to FIX after the counter reaches WIDTH-1.
//      Multiply: shift-add on a 2*WIDTH accumulator.
//      Divide: restoring shift-subtract; remainder is WIDTH+1 bits internally.
//    FIX: one edge (E33) applies the sign correction and registers Hi_out/Lo_out; go to DONE.
//    DONE: HiLo_Ld=1 for exactly one cycle, Busy=0; next edge returns to IDLE.
//  - Latency: Start edge E0 -> HiLo_Ld high in the cycle after E33 (WIDTH+1 edges).
//    The next Start is accepted at the earliest at E35.
//  - Start in RUN, FIX or DONE: ignored. A/B/Op changes after E0 have no effect.
//  - Hi_out/Lo_out hold their last result until the next FIX edge or Clr. They are valid while HiLo_Ld=1.
//  - Signed multiply: the product is negated (two's complement over 2*WIDTH) when sign(A) != sign(B).
//  - Signed divide: the quotient is negated when the signs differ; the remainder takes the sign of A.
//    Invariant: A = Lo_out*B + Hi_out.
//  - Divide by zero (B=0, DIV or DIVU): no trap. Lo_out = all ones, Hi_out = A (original value, unsigned and signed alike).
//    Full latency still applies.
//  - DIV 0x80000000 / 0xFFFFFFFF: Lo_out=0x80000000, Hi_out=0 (wrap, no flag).
//  - MULT with 0x80000000 operands: the magnitude 2^31 must be handled in WIDTH bits unsigned, with no overflow.
//    Example: 0x80000000*0x80000000 -> Hi=0x40000000, Lo=0.
// TESTING
//  T1 MULTU A=6 B=7 -> HiLo_Ld one cycle after E33; Hi=0x00000000 Lo=0x0000002A; Busy low in DONE.
//  T2 MULT A=0xFFFFFFFD(-3) B=5 -> Hi=0xFFFFFFFF Lo=0xFFFFFFF1; MULTU 0xFFFFFFFF^2 -> Hi=0xFFFFFFFE Lo=0x00000001.
//  T3 DIV A=0xFFFFFFF9(-7) B=2 -> Lo=0xFFFFFFFD Hi=0xFFFFFFFF; DIVU A=100 B=7 -> Lo=14 Hi=2.
//  T4 DIVU A=7 B=0 -> Lo=0xFFFFFFFF Hi=7; DIV 0x80000000/0xFFFFFFFF -> Lo=0x80000000 Hi=0.
//  T5 Start MULTU 3*3, re-pulse Start with DIVU 9/3 at E10 -> the second request is ignored; exactly one HiLo_Ld; Lo=9.
//  T6 Start DIV, assert Clr asynchronously mid-cycle at E15 -> outputs 0 immediately; no HiLo_Ld.
//     After Clr drops, a new MULTU 2*2 gives Lo=4 with full latency.

Source files
------------

// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between the pipeline and the multiply/divide engine.
interface mult_div_if #(parameter int WIDTH = 32);
    logic             start;
    logic [1:0]       op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             hilo_ld;
    logic [WIDTH-1:0] hi_out;
    logic [WIDTH-1:0] lo_out;
    modport master (output start, op, a, b, input busy, hilo_ld, hi_out, lo_out);
    modport slave (input start, op, a, b, output busy, hilo_ld, hi_out, lo_out);
endinterface

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU engine producing HI/LO with a one-cycle load strobe.
module mult_div_unit #(parameter int WIDTH = 32) (
    input logic       Clk,
    input logic       Clr,
    mult_div_if.slave bus
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, RUN, FIX, DONE} state_t;
    state_t             state, state_n;
    logic [CW-1:0]      cnt;
    logic [2*WIDTH-1:0] prod, prod_n, res;
    logic [WIDTH-1:0]   mag, abs_a, abs_b, quo, rem;
    logic [WIDTH:0]     upper, shifted, sub;
    logic               is_div, neg_q, neg_r, dz, sa, sb, ge;

    always_ff @(posedge Clk or posedge Clr)
        if (Clr) state <= IDLE;
        else state <= state_n;

    always_comb begin
        state_n = state;
        bus.busy = 1'b0;
        bus.hilo_ld = 1'b0;
        state_n = state == IDLE ? (bus.start ? RUN : IDLE) :
                  state == RUN  ? (cnt == CW'(WIDTH-1) ? FIX : RUN) :
                  state == FIX  ? DONE : IDLE;
        bus.busy = state == RUN || state == FIX;
        bus.hilo_ld = state == DONE;
    end

    // prod holds {accumulator, multiplier} for multiply and {remainder, quotient} for divide
    always_comb begin
        sa = bus.op[0] & bus.a[WIDTH-1];
        sb = bus.op[0] & bus.b[WIDTH-1];
        abs_a = sa ? -bus.a : bus.a;
        abs_b = sb ? -bus.b : bus.b;
        upper = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mag} : '0);
        shifted = {prod[2*WIDTH-1:WIDTH], prod[WIDTH-1]};
        ge = shifted >= {1'b0, mag};
        sub = shifted - {1'b0, mag};
        prod_n = is_div ? {WIDTH'(ge ? sub : shifted), prod[WIDTH-2:0], ge} : {upper, prod[WIDTH-1:1]};
        res = neg_q ? -prod : prod;
        quo = neg_q ? -prod[WIDTH-1:0] : prod[WIDTH-1:0];
        rem = neg_r ? -prod[2*WIDTH-1:WIDTH] : prod[2*WIDTH-1:WIDTH];
    end

    always_ff @(posedge Clk or posedge Clr)
        if (Clr) begin
            cnt <= '0;
            prod <= '0;
            mag <= '0;
            is_div <= 1'b0;
            neg_q <= 1'b0;
            neg_r <= 1'b0;
            dz <= 1'b0;
            bus.hi_out <= '0;
            bus.lo_out <= '0;
        end else if (state == IDLE && bus.start) begin
            cnt <= '0;
            is_div <= bus.op[1];
            neg_q <= sa ^ sb;
            neg_r <= sa;
            dz <= bus.op[1] && bus.b == '0;
            mag <= bus.op[1] ? abs_b : abs_a;
            prod <= {{WIDTH{1'b0}}, bus.op[1] ? abs_a : abs_b};
        end else if (state == RUN) begin
            cnt <= cnt + 1'b1;
            prod <= prod_n;
        end else if (state == FIX) begin
            // a zero divisor leaves |A| as remainder, so the sign fix restores the original A
            bus.hi_out <= is_div ? rem : res[2*WIDTH-1:WIDTH];
            bus.lo_out <= is_div ? (dz ? '1 : quo) : res[WIDTH-1:0];
        end
endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: directed checks of the multiply/divide engine against hand-computed HI/LO values.
module tb_mult_div_unit;
    logic clk = 1'b0;
    logic clr = 1'b1;
    int   checks = 0;
    int   failures = 0;
    mult_div_if #(.WIDTH(32)) bus ();
    mult_div_unit #(.WIDTH(32)) dut (.Clk(clk), .Clr(clr), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] x, input logic [31:0] y,
                         input logic [31:0] eh, input logic [31:0] el);
        int   n;
        logic busy_ok;
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = o;
        bus.a = x;
        bus.b = y;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        bus.a = ~x;
        bus.b = ~y;
        bus.op = ~o;
        n = 0;
        busy_ok = 1'b1;
        while (!bus.hilo_ld && n < 40) begin
            if (!bus.busy) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            n++;
        end
        chk({tag, "_latency"}, n, 33);
        chk({tag, "_busy_run"}, busy_ok, 1);
        chk({tag, "_busy_done"}, bus.busy, 0);
        chk({tag, "_hi"}, bus.hi_out, eh);
        chk({tag, "_lo"}, bus.lo_out, el);
        @(posedge clk);
        #1;
        chk({tag, "_ld_drop"}, bus.hilo_ld, 0);
    endtask

    initial begin
        int          pulses;
        int          at;
        logic [31:0] lo_seen;
        bus.start = 1'b0;
        bus.op = 2'b00;
        bus.a = '0;
        bus.b = '0;
        #12;
        chk("rst_busy", bus.busy, 0);
        chk("rst_ld", bus.hilo_ld, 0);
        chk("rst_hi", bus.hi_out, 0);
        chk("rst_lo", bus.lo_out, 0);
        @(negedge clk);
        clr = 1'b0;
        do_op("multu_6x7", 2'b00, 32'd6, 32'd7, 32'h0, 32'h2A);
        do_op("mult_m3x5", 2'b01, 32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF, 32'hFFFFFFF1);
        do_op("multu_max", 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h1);
        do_op("mult_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000, 32'h0);
        do_op("multu_big", 2'b00, 32'h80000000, 32'd2, 32'h1, 32'h0);
        do_op("div_m7d2", 2'b11, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD);
        do_op("div_7dm2", 2'b11, 32'd7, 32'hFFFFFFFE, 32'h1, 32'hFFFFFFFD);
        do_op("divu_100d7", 2'b10, 32'd100, 32'd7, 32'd2, 32'd14);
        do_op("divu_big", 2'b10, 32'hFFFFFFF9, 32'd2, 32'h1, 32'h7FFFFFFC);
        do_op("divu_by0", 2'b10, 32'd7, 32'd0, 32'd7, 32'hFFFFFFFF);
        do_op("div_neg_by0", 2'b11, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF);
        do_op("div_wrap", 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'h0, 32'h80000000);
        // second Start while running must be ignored
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b00;
        bus.a = 32'd3;
        bus.b = 32'd3;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        pulses = 0;
        at = 0;
        lo_seen = '0;
        for (int k = 1; k <= 45; k++) begin
            if (k == 10) begin
                @(negedge clk);
                bus.start = 1'b1;
                bus.op = 2'b10;
                bus.a = 32'd9;
                bus.b = 32'd3;
            end
            @(posedge clk);
            #1;
            if (k == 10) bus.start = 1'b0;
            if (bus.hilo_ld) begin
                pulses++;
                at = k;
                lo_seen = bus.lo_out;
            end
        end
        chk("restart_pulses", pulses, 1);
        chk("restart_at", at, 33);
        chk("restart_lo", lo_seen, 9);
        // asynchronous clear mid-operation
        @(negedge clk);
        bus.start = 1'b1;
        bus.op = 2'b11;
        bus.a = 32'hFFFFFFF9;
        bus.b = 32'd2;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        repeat (15) @(posedge clk);
        #3;
        clr = 1'b1;
        #1;
        chk("clr_busy", bus.busy, 0);
        chk("clr_hi", bus.hi_out, 0);
        chk("clr_lo", bus.lo_out, 0);
        @(negedge clk);
        @(negedge clk);
        clr = 1'b0;
        pulses = 0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.hilo_ld || bus.busy) pulses++;
        end
        chk("clr_no_ld", pulses, 0);
        do_op("multu_2x2", 2'b00, 32'd2, 32'd2, 32'h0, 32'd4);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
